seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed 4-digit 7-segment scanner; downstream of time_counter, drives board display pins.
//  Shows HH.MM from binary hours/minutes.
//  Snapshots inputs once per scan frame so no digit tears mid-frame.
//  dp between hours and minutes blinks once per second from one_second_pulse.
// PARAMETERS
//  CLK_HZ       100_000_000  input clock frequency
//  REFRESH_HZ   1000         per-digit refresh rate; SCAN_DIV = CLK_HZ/(4*REFRESH_HZ) cycles per digit slot
//  BLANK_CYC    16           cycles at start of each slot with all anodes off (anti-ghosting); < SCAN_DIV
//  LZ_BLANK     1            1 = blank hours-tens digit when it is 0
// PORTS
//  clk               in   1  system clock
//  reset             in   1  synchronous, active-low reset
//  one_second_pulse  in   1  1-cycle strobe, 1 Hz
//  hours             in   5  binary 0..23
//  minutes           in   6  binary 0..59
//  seg               out  7  segments a..g, active-low
//  an                out  4  digit anodes, active-low; an[3]=hours tens .. an[0]=minutes units
//  dp                out  1  decimal point, active-low
// BEHAVIOUR
//  Reset (reset==0 at posedge): seg=7'h7F, an=4'hF, dp=1; slot_cnt=0, digit=3, colon=0, snapshots=0.
//  Outputs are registered, with 1 cycle from internal state to pins.
//  slot_cnt counts 0..SCAN_DIV-1 and wraps.
//    On wrap, digit decrements 3->2->1->0->3.
//  Snapshot: hours/minutes are latched into h_q/m_q on the cycle slot_cnt wraps while digit==0.
//    That is the frame boundary; the next frame uses the new values.
//  Slot timing:
//    slot_cnt < BLANK_CYC: an=4'hF, seg=7'h7F, dp=1.
//    Otherwise exactly one an bit is low, selected by digit.
//  Digit values: h_q/10, h_q%10, m_q/10, m_q%10.
//    Constant divide by 10 on <=6-bit values; 4-bit results.
//  Encoding: seg via seg_decoder.
//    Digits 0-9 use standard patterns.
//    digit==3 with LZ_BLANK and value 0 gives SEG_BLANK.
//  Range error: if h_q>23 or m_q>59, all four digits show SEG_DASH and dp stays off.
//    This is checked on the snapshot, not on live inputs.
//  Colon: colon toggles on every one_second_pulse.
//    dp=~colon only while digit==2 is lit; dp=1 in all other slots.
//  Simultaneous events:
//    A pulse on the snapshot cycle toggles colon and latches the snapshot in the same cycle.
//    Both take effect from the next cycle.
//  Mid-frame input changes are invisible until the next frame boundary.
//  Reset mid-scan aborts the frame, and the display is dark on the next cycle.
//    After reset release, the first frame shows 00.00 (hours tens blank if LZ_BLANK), colon off.
//    New input values appear one frame later.
// STRUCTURE
//  Shared package clock_pkg: SEG_BLANK=7'h7F, SEG_DASH=7'h3F, DIGIT_PAT[0..9] active-low table.
//  Also in clock_pkg: HOURS_MAX=23, MINUTES_MAX=59 (shared with time_counter).
//  One sub-module: seg_decoder (4-bit value + blank + dash -> 7-bit pattern, combinational).
//  Everything else stays in this module: slot counter, digit index, snapshot, colon flop, output registers.
// TESTING  (CLK_HZ=400, REFRESH_HZ=10 -> SCAN_DIV=10, BLANK_CYC=2)
//  1 Reset: hold reset low 5 cycles -> seg=7F, an=F, dp=1 every cycle.
//    Release -> first lit slot is an=0111 at cycle 3.
//  2 hours=13, minutes=47, wait one frame (40 cycles) -> scan sequence:
//    an=0111 '1', an=1011 '3', an=1101 '4', an=1110 '7'.
//    Each digit is lit 8 cycles after 2 blank cycles.
//  3 hours=5, LZ_BLANK=1 -> an[3] slot shows seg=7F.
//    With LZ_BLANK=0, the same slot shows the '0' pattern.
//  4 Change minutes 47->48 while digit==1 is lit -> current frame still shows 47.
//    The next frame shows 48.
//  5 Three one_second_pulses -> dp low in digit-2 slots after pulses 1 and 3, high after pulse 2.
//    dp is never low in other slots.
//  6 minutes=60 -> after the snapshot, all digits show 3F and dp=1.
//    Fix to 59 -> normal display resumes on the following frame.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: display glyphs, digit indices and time limits shared by the clock datapath
package clock_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] DIGIT_PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [4:0] HOURS_MAX = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;
  typedef enum logic [1:0] {DIG_MU, DIG_MT, DIG_HU, DIG_HT} digit_t;
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: binary time inputs and active-low display pins
interface seg_scan_driver_if;
  logic one_second_pulse;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp;
  modport master(output one_second_pulse, hours, minutes, input seg, an, dp);
  modport slave(input one_second_pulse, hours, minutes, output seg, an, dp);
endinterface

// File: rtl/seg_decoder.sv
// seg_decoder: 4-bit digit value to active-low 7-segment pattern, dash overrides blank
module seg_decoder
  import clock_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] pattern
);
  always_comb pattern = dash ? SEG_DASH : (blank || value > 4'd9) ? SEG_BLANK : DIGIT_PAT[value];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit HH.MM multiplexed display scanner with per-frame snapshot and blinking dp
module seg_scan_driver
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_CYC = 16,
  parameter int LZ_BLANK = 1
) (
  input logic clk,
  input logic reset,
  seg_scan_driver_if.slave bus
);
  localparam int SCAN_DIV = CLK_HZ / (4 * REFRESH_HZ);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [SW-1:0] slot_q, slot_d;
  digit_t digit_q, digit_d;
  logic [4:0] h_q, h_d;
  logic [5:0] m_q, m_d;
  logic colon_q, colon_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic dp_q, dp_d;
  logic wrap, lit, err, blank;
  logic [3:0] value;
  logic [6:0] pattern;
  seg_decoder u_dec (.value(value), .blank(blank), .dash(err), .pattern(pattern));
  // Snapshot is taken only at the frame boundary so a frame never mixes old and new digits
  always_comb begin
    wrap = slot_q == SW'(SCAN_DIV - 1);
    lit = slot_q >= SW'(BLANK_CYC);
    err = h_q > HOURS_MAX || m_q > MINUTES_MAX;
    value = digit_q == DIG_HT ? 4'(h_q / 5'd10) :
            digit_q == DIG_HU ? 4'(h_q % 5'd10) :
            digit_q == DIG_MT ? 4'(m_q / 6'd10) : 4'(m_q % 6'd10);
    blank = LZ_BLANK != 0 && digit_q == DIG_HT && value == 4'd0;
    slot_d = wrap ? '0 : slot_q + 1'b1;
    digit_d = wrap ? digit_t'(digit_q - 2'd1) : digit_q;
    h_d = wrap && digit_q == DIG_MU ? bus.hours : h_q;
    m_d = wrap && digit_q == DIG_MU ? bus.minutes : m_q;
    colon_d = colon_q ^ bus.one_second_pulse;
    seg_d = lit ? pattern : SEG_BLANK;
    an_d = lit ? ~(4'b0001 << digit_q) : 4'hF;
    dp_d = !(lit && digit_q == DIG_HU && colon_q && !err);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q <= '0;
      digit_q <= DIG_HT;
      h_q <= '0;
      m_q <= '0;
      colon_q <= 1'b0;
      seg_q <= SEG_BLANK;
      an_q <= 4'hF;
      dp_q <= 1'b1;
    end else begin
      slot_q <= slot_d;
      digit_q <= digit_d;
      h_q <= h_d;
      m_q <= m_d;
      colon_q <= colon_d;
      seg_q <= seg_d;
      an_q <= an_d;
      dp_q <= dp_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.an = an_q;
  assign bus.dp = dp_q;
endmodule
